vred_seq_reduce_unit: RTL and testbench

//  Multi-beat vector reduction engine: folds a stream of DATA_WIDTH-bit element beats plus a scalar seed into one scalar.

---
 rtl/vred_pkg.sv | 74 +++++++
 rtl/vred_lane_tree.sv | 44 ++++
 rtl/vred_seq_reduce_unit.sv | 109 ++++++++++
 tb/tb_vred_seq_reduce_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vred_pkg.sv
// Shared encodings and per-element helpers for the sequential vector reduction unit.
// All element values travel as 64-bit words; only the low SEW bits are meaningful.
package vred_pkg;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_MINU = 3'b100;
  localparam logic [2:0] OP_MIN  = 3'b101;
  localparam logic [2:0] OP_MAXU = 3'b110;
  localparam logic [2:0] OP_MAX  = 3'b111;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  function automatic int sew_bits(input logic [1:0] sew);
    return 8 << sew;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00ff;
      SEW_16:  return 64'h0000_0000_0000_ffff;
      SEW_32:  return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

  function automatic logic [63:0] sew_msb(input logic [1:0] sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_0080;
      SEW_16:  return 64'h0000_0000_0000_8000;
      SEW_32:  return 64'h0000_0000_8000_0000;
      default: return 64'h8000_0000_0000_0000;
    endcase
  endfunction

  function automatic logic [63:0] identity(input logic [2:0] op, input logic [1:0] sew);
    case (op)
      OP_AND, OP_MINU: return sew_mask(sew);
      OP_MIN:          return sew_mask(sew) ^ sew_msb(sew);
      OP_MAX:          return sew_msb(sew);
      default:         return 64'h0;
    endcase
  endfunction

  // Signed compares flip the SEW sign bit so one unsigned comparator serves both.
  function automatic logic [63:0] elem_op(input logic [2:0] op, input logic [1:0] sew,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic mm_en);
    logic [63:0] m, am, bm, flip;
    logic        a_lt_b;
    m      = sew_mask(sew);
    am     = a & m;
    bm     = b & m;
    flip   = op[0] ? sew_msb(sew) : 64'h0;
    a_lt_b = (am ^ flip) < (bm ^ flip);
    if (!mm_en && op[2]) return am;
    case (op)
      OP_SUM:          return (am + bm) & m;
      OP_AND:          return am & bm;
      OP_OR:           return am | bm;
      OP_XOR:          return am ^ bm;
      OP_MINU, OP_MIN: return a_lt_b ? am : bm;
      default:         return a_lt_b ? bm : am;
    endcase
  endfunction

endpackage

// File: rtl/vred_lane_tree.sv
// Combinational masked reduction of one beat down to a single SEW-wide value.
// Byte-granular slots; slots with no element at the current SEW carry the op identity.
module vred_lane_tree
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MIN_MAX_ENABLE = 1
) (
  input  logic [1:0]              sew,
  input  logic [2:0]              op,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] mask,
  output logic [63:0]             red
);

  localparam int  NB    = DATA_WIDTH / 8;
  localparam logic MM_EN = (MIN_MAX_ENABLE != 0);

  logic [63:0]   nd [NB];
  logic [63:0]   el, idv, m;
  logic [NB-1:0] msh;
  int            w;

  always_comb begin
    w   = sew_bits(sew);
    idv = identity(op, sew);
    m   = sew_mask(sew);
    el  = 64'h0;
    msh = '0;
    for (int i = 0; i < NB; i++) begin
      el    = 64'(data >> (i * w));
      msh   = mask >> ((i * w) / 8);
      nd[i] = ((i * w) < DATA_WIDTH && msh[0]) ? (el & m) : idv;
    end
    // Pairwise fold, stride doubling each level.
    for (int s = 1; s < NB; s = s * 2) begin
      for (int i = 0; i + s < NB; i = i + 2 * s) begin
        nd[i] = elem_op(op, sew, nd[i], nd[i+s], MM_EN);
      end
    end
    red = nd[0];
  end

endmodule

// File: rtl/vred_seq_reduce_unit.sv
// Multi-beat vector reduction: seed + stream of masked element beats folded into one scalar.
// Beat -> lane tree -> stage reg -> accumulator; one beat per cycle while in RUN.
module vred_seq_reduce_unit
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 3,
  parameter int MIN_MAX_ENABLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OPSEL_WIDTH-1:0]  op,
  input  logic [63:0]             scalar_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_data,
  output logic                    busy
);

  localparam logic MM_EN = (MIN_MAX_ENABLE != 0);

  state_e                 state_q, state_d;
  logic [SEW_WIDTH-1:0]   sew_q, sew_d;
  logic [OPSEL_WIDTH-1:0] op_q, op_d;
  logic [63:0]            acc_q, acc_d;
  logic [63:0]            stage_q, stage_d;
  logic                   stage_vld_q, stage_vld_d;
  logic [63:0]            tree_red;

  vred_lane_tree #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MIN_MAX_ENABLE (MIN_MAX_ENABLE)
  ) u_tree (
    .sew  (sew_q),
    .op   (op_q),
    .data (in_data),
    .mask (in_mask),
    .red  (tree_red)
  );

  always_comb begin
    state_d     = state_q;
    sew_d       = sew_q;
    op_d        = op_q;
    acc_d       = acc_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 64'h0;
    busy        = (state_q != ST_IDLE);

    // Whatever sat in the stage reg last cycle folds now, in any state.
    if (stage_vld_q) acc_d = elem_op(op_q, sew_q, acc_q, stage_q, MM_EN);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sew_d   = sew;
          op_d    = op;
          acc_d   = scalar_in & sew_mask(sew);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          stage_d     = tree_red;
          stage_vld_d = 1'b1;
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sew_q       <= '0;
      op_q        <= '0;
      acc_q       <= 64'h0;
      stage_q     <= 64'h0;
      stage_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sew_q       <= sew_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
    end
  end

endmodule

// File: tb/tb_vred_seq_reduce_unit.sv
// Self-checking bench for vred_seq_reduce_unit: expected results queued at start, checked at output.
module tb_vred_seq_reduce_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sew = 2'b00;
  logic [2:0]  op = 3'b000;
  logic [63:0] scalar_in = 64'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'h0;
  logic [7:0]  in_mask = 8'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];

  vred_seq_reduce_unit #(
    .DATA_WIDTH(64), .SEW_WIDTH(2), .OPSEL_WIDTH(3), .MIN_MAX_ENABLE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sew(sew), .op(op), .scalar_in(scalar_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sew/op/seed are scrambled right after start to show they are latched.
  task automatic do_start(input logic [1:0] s, input logic [2:0] o, input logic [63:0] seed);
    start = 1'b1; sew = s; op = o; scalar_in = seed;
    tick;
    start = 1'b0; sew = ~s; op = ~o; scalar_in = ~seed;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] m, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_mask = m; in_last = l;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    if (!in_ready) begin
      n_assert++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    ok = out_valid;
  endtask

  task automatic get_result(input string name);
    logic        ok;
    logic [63:0] exp;
    wait_out(ok);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hdead_beef_dead_beef;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
    end else if (out_data !== exp) begin
      n_fail++;
      $display("FAIL %s: out_data=%h required %h", name, out_data, exp);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    n_assert += 4;
    if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (out_data !== 64'h0)  begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    rst = 1'b1;
    tick;
    in_valid = 1'b1; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_beat: busy=%b required 0", busy); end
  endtask

  task automatic test_sum8_latency;
    sb.push_back(64'h29);
    do_start(SEW8(), 3'b000, 64'h5);
    n_assert += 2;
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL sum8_busy: got %b required 1", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sum8_in_ready: got %b required 1", in_ready); end
    send(64'h0807060504030201, 8'hff, 1'b1);
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sum8_lat_c1: out_valid=%b required 0", out_valid); end
    tick;
    n_assert++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sum8_lat_c2: out_valid=%b required 1", out_valid); end
    get_result("sum8");
  endtask

  function automatic logic [1:0] SEW8();
    return 2'b00;
  endfunction

  task automatic test_max32;
    sb.push_back(64'h3);
    do_start(2'b10, 3'b111, 64'h0);
    send(64'hffffffff_00000003, 8'hff, 1'b0);
    send(64'h80000000_00000002, 8'hff, 1'b1);
    get_result("max32");
    sb.push_back(64'hffff_ffff);
    do_start(2'b10, 3'b110, 64'h0);
    send(64'hffffffff_00000003, 8'hff, 1'b0);
    send(64'h80000000_00000002, 8'hff, 1'b1);
    get_result("maxu32");
  endtask

  task automatic test_minu16;
    sb.push_back(64'h10);
    do_start(2'b01, 3'b100, 64'h1234);
    send(64'h0001_0001_0001_0010, 8'h03, 1'b1);
    get_result("minu16_mask");
  endtask

  task automatic test_misc;
    sb.push_back(64'hf00f);
    do_start(2'b01, 3'b001, 64'habcd_0000_0000_ffff);
    send(64'hffff_f0ff_ff0f_ffff, 8'hff, 1'b1);
    get_result("and16");
    sb.push_back(64'hf0);
    do_start(2'b00, 3'b101, 64'h10);
    send(64'h80808080_807ff005, 8'h07, 1'b1);
    get_result("min8_signed");
    sb.push_back(64'h0f);
    do_start(2'b00, 3'b010, 64'h01);
    send(64'h00000000_0000_0402, 8'hff, 1'b0);
    send(64'hf0f0f0f0_f0f0_f008, 8'h01, 1'b1);
    get_result("or8");
  endtask

  task automatic test_back_to_back;
    sb.push_back(64'hf);
    do_start(2'b11, 3'b011, 64'h0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 64'h1 << i; in_mask = 8'hff; in_last = (i == 3);
      n_assert++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready); end
      tick;
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("xor64_b2b");
  endtask

  task automatic test_stall;
    logic ok;
    sb.push_back(64'h010a);
    do_start(2'b01, 3'b000, 64'h0100);
    send(64'h0004_0003_0002_0001, 8'hff, 1'b1);
    wait_out(ok);
    for (int k = 0; k < 5; k++) begin
      n_assert += 3;
      if (out_valid !== 1'b1)      begin n_fail++; $display("FAIL stall_valid_%0d: got %b required 1", k, out_valid); end
      if (out_data !== 64'h010a)   begin n_fail++; $display("FAIL stall_data_%0d: got %h required 010a", k, out_data); end
      if (busy !== 1'b1)           begin n_fail++; $display("FAIL stall_busy_%0d: got %b required 1", k, busy); end
      if (k == 2) begin start = 1'b1; sew = 2'b00; op = 3'b011; scalar_in = 64'h55; end
      tick;
      start = 1'b0;
    end
    get_result("stall_sum16");
    n_assert += 2;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL stall_start_ignored: busy=%b required 0", busy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after_consume: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    do_start(2'b00, 3'b000, 64'h3);
    send(64'h0101010101010101, 8'hff, 1'b0);
    send(64'h0202020202020202, 8'hff, 1'b0);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    n_assert += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rstmid_in_ready: got %b required 0", in_ready); end
    sb.push_back(64'h7);
    do_start(2'b00, 3'b000, 64'h7);
    send(64'hffffffffffffffff, 8'h00, 1'b1);
    get_result("rstmid_seed_only");
  endtask

  initial begin
    test_reset;
    test_sum8_latency;
    test_max32;
    test_minu16;
    test_misc;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
